// File: rtl/main_cpu_cpu_debug_pkg.sv
// Shared types and jdo field positions for the CPU debug memory master.
package main_cpu_cpu_debug_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RD   = 2'd1,
      WR   = 2'd2,
      DONE = 2'd3
   } dbg_state_t;

   localparam int JDO_RD_BIT    = 35;
   localparam int JDO_WDATA_LSB = 3;
   localparam int JDO_ADDR_LSB  = 2;
   localparam int MON_DATA_W    = 32;

endpackage

// File: rtl/main_cpu_cpu_debug_wait_timer.sv
// Counts waitrequest-stalled cycles; expire stays high once the count reaches TIMEOUT.
module main_cpu_cpu_debug_wait_timer #(
   parameter int TIMEOUT = 255
) (
   input  logic clk,
   input  logic reset_n,
   input  logic load,
   input  logic enable,
   output logic expire
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);

   logic [CNT_W-1:0] count;

   assign expire = (count == CNT_W'(TIMEOUT));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count <= '0;
      end else if (load) begin
         count <= '0;
      end else if (enable && !expire) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/main_cpu_cpu_debug_mem_master.sv
// Turns JTAG OCI-memory commands into single-word Avalon-MM accesses with auto-increment and timeout.
module main_cpu_cpu_debug_mem_master
   import main_cpu_cpu_debug_pkg::*;
#(
   parameter int ADDR_W  = 10,
   parameter int TIMEOUT = 255
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [37:0]           jdo,
   input  logic                  take_action_ocimem_a,
   input  logic                  take_no_action_ocimem_a,
   input  logic                  take_action_ocimem_b,
   output logic [ADDR_W+1:0]     avm_address,
   output logic                  avm_read,
   output logic                  avm_write,
   output logic [31:0]           avm_writedata,
   output logic [3:0]            avm_byteenable,
   input  logic [31:0]           avm_readdata,
   input  logic                  avm_waitrequest,
   output logic [MON_DATA_W-1:0] MonDReg,
   output logic                  monitor_ready,
   output logic                  monitor_error
);

   dbg_state_t          state, next_state;
   logic [ADDR_W-1:0]   mon_a_reg;
   logic                strobe;
   logic                timer_load;
   logic                expire;
   logic                complete;
   logic                timed_out;
   logic                any_take;
   logic                unused_jdo;

   assign unused_jdo = &{1'b0, jdo[37:36], jdo[1:0]};

   main_cpu_cpu_debug_wait_timer #(.TIMEOUT(TIMEOUT)) u_wait_timer (
      .clk     (clk),
      .reset_n (reset_n),
      .load    (timer_load),
      .enable  (strobe & avm_waitrequest),
      .expire  (expire)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Strobe is masked in the expiry cycle so the abort happens without a final stalled beat.
   always_comb begin
      next_state = state;
      strobe     = 1'b0;
      timer_load = 1'b0;
      case (state)
         IDLE: begin
            if (take_action_ocimem_a) begin
               if (jdo[JDO_RD_BIT]) begin
                  next_state = RD;
                  timer_load = 1'b1;
               end
            end else if (take_action_ocimem_b) begin
               next_state = WR;
               timer_load = 1'b1;
            end else if (take_no_action_ocimem_a) begin
               next_state = RD;
               timer_load = 1'b1;
            end
         end
         RD, WR: begin
            strobe = !expire;
            if (expire) begin
               next_state = IDLE;
            end else if (!avm_waitrequest) begin
               next_state = DONE;
            end
         end
         DONE: next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   assign complete       = strobe & !avm_waitrequest;
   assign timed_out      = ((state == RD) || (state == WR)) && expire;
   assign any_take       = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
   assign avm_read       = strobe && (state == RD);
   assign avm_write      = strobe && (state == WR);
   assign avm_address    = {mon_a_reg, 2'b00};
   assign avm_writedata  = MonDReg;
   assign avm_byteenable = 4'hF;
   assign monitor_ready  = (state == IDLE);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mon_a_reg <= '0;
         MonDReg   <= '0;
      end else begin
         if (state == IDLE && take_action_ocimem_a) begin
            mon_a_reg <= jdo[JDO_ADDR_LSB +: ADDR_W];
         end else if (state == DONE) begin
            mon_a_reg <= mon_a_reg + 1'b1;
         end
         if (state == IDLE && !take_action_ocimem_a && take_action_ocimem_b) begin
            MonDReg <= jdo[JDO_WDATA_LSB +: MON_DATA_W];
         end else if (state == RD && complete) begin
            MonDReg <= avm_readdata;
         end
      end
   end

   // An accepted address load clears the error, but a losing command in the same cycle re-flags it.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         monitor_error <= 1'b0;
      end else if (state == IDLE) begin
         if (take_action_ocimem_a) begin
            monitor_error <= take_action_ocimem_b | take_no_action_ocimem_a;
         end else if (take_action_ocimem_b && take_no_action_ocimem_a) begin
            monitor_error <= 1'b1;
         end
      end else if (any_take || timed_out) begin
         monitor_error <= 1'b1;
      end
   end

endmodule

// File: tb/tb_main_cpu_cpu_debug_mem_master.sv
// Scoreboard bench: expected Avalon accesses are queued by the stimulus and checked by a monitor.
module tb_main_cpu_cpu_debug_mem_master;

   logic        clk;
   logic        reset_n;
   logic [37:0] jdo;
   logic        take_action_ocimem_a;
   logic        take_no_action_ocimem_a;
   logic        take_action_ocimem_b;
   logic [11:0] avm_address;
   logic        avm_read;
   logic        avm_write;
   logic [31:0] avm_writedata;
   logic [3:0]  avm_byteenable;
   logic [31:0] avm_readdata;
   logic        avm_waitrequest;
   logic [31:0] MonDReg;
   logic        monitor_ready;
   logic        monitor_error;

   typedef struct {
      bit          is_wr;
      logic [11:0] addr;
      logic [31:0] data;
   } acc_t;

   acc_t exp_q[$];
   int   tests = 0;
   int   fails = 0;

   main_cpu_cpu_debug_mem_master #(.ADDR_W(10), .TIMEOUT(255)) dut (
      .clk                     (clk),
      .reset_n                 (reset_n),
      .jdo                     (jdo),
      .take_action_ocimem_a    (take_action_ocimem_a),
      .take_no_action_ocimem_a (take_no_action_ocimem_a),
      .take_action_ocimem_b    (take_action_ocimem_b),
      .avm_address             (avm_address),
      .avm_read                (avm_read),
      .avm_write               (avm_write),
      .avm_writedata           (avm_writedata),
      .avm_byteenable          (avm_byteenable),
      .avm_readdata            (avm_readdata),
      .avm_waitrequest         (avm_waitrequest),
      .MonDReg                 (MonDReg),
      .monitor_ready           (monitor_ready),
      .monitor_error           (monitor_error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
      end
   endtask

   task automatic applyStimulus(input logic a, input logic na, input logic b, input logic [37:0] j);
      @(posedge clk);
      #1;
      take_action_ocimem_a    = a;
      take_no_action_ocimem_a = na;
      take_action_ocimem_b    = b;
      jdo                     = j;
      @(posedge clk);
      #1;
      take_action_ocimem_a    = 1'b0;
      take_no_action_ocimem_a = 1'b0;
      take_action_ocimem_b    = 1'b0;
      jdo                     = '0;
   endtask

   task automatic waitReady(input int budget, output int n);
      n = 0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         n++;
         if (monitor_ready) break;
      end
      if (!monitor_ready) begin
         tests++;
         fails++;
         $display("[TB] FAIL ready_timeout: got ready 0 after %0d cycles expected 1", n);
      end
   endtask

   function automatic logic [37:0] cmdA(input logic rd, input logic [9:0] addr);
      return {2'b00, rd, 23'd0, addr, 2'b00};
   endfunction

   function automatic logic [37:0] cmdB(input logic [31:0] data);
      return {3'b000, data, 3'b000};
   endfunction

   function automatic acc_t mkAcc(input bit is_wr, input logic [11:0] addr, input logic [31:0] data);
      acc_t r;
      r.is_wr = is_wr;
      r.addr  = addr;
      r.data  = data;
      return r;
   endfunction

   // Every completed handshake must match the oldest outstanding expectation.
   always @(negedge clk) begin
      acc_t e;
      if (reset_n && (avm_read || avm_write) && !avm_waitrequest) begin
         if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("[TB] FAIL unexpected_access: got addr 0x%0h expected none", avm_address);
         end else begin
            e = exp_q.pop_front();
            checkOutput("acc_is_write", {31'd0, avm_write}, {31'd0, e.is_wr});
            checkOutput("acc_addr", {20'd0, avm_address}, {20'd0, e.addr});
            checkOutput("acc_byteenable", {28'd0, avm_byteenable}, 32'hF);
            if (e.is_wr) checkOutput("acc_wdata", avm_writedata, e.data);
         end
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got no end expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int n;
      int held;
      int strobes;

      reset_n                 = 1'b0;
      jdo                     = '0;
      take_action_ocimem_a    = 1'b0;
      take_no_action_ocimem_a = 1'b0;
      take_action_ocimem_b    = 1'b0;
      avm_readdata            = '0;
      avm_waitrequest         = 1'b0;
      repeat (2) @(negedge clk);
      checkOutput("rst_ready", {31'd0, monitor_ready}, 32'd1);
      checkOutput("rst_error", {31'd0, monitor_error}, 32'd0);
      checkOutput("rst_mondreg", MonDReg, 32'd0);
      checkOutput("rst_strobes", {30'd0, avm_read, avm_write}, 32'd0);
      checkOutput("rst_addr", {20'd0, avm_address}, 32'd0);
      @(posedge clk);
      #1 reset_n = 1'b1;

      // Zero-wait read with address load
      avm_readdata = 32'hDEADBEEF;
      exp_q.push_back(mkAcc(1'b0, 12'h040, 32'hDEADBEEF));
      applyStimulus(1'b1, 1'b0, 1'b0, cmdA(1'b1, 10'h010));
      waitReady(20, n);
      checkOutput("rd_latency", n, 3);
      checkOutput("rd_mondreg", MonDReg, 32'hDEADBEEF);
      checkOutput("rd_next_addr", {20'd0, avm_address}, 32'h044);

      // Streaming reads wrapping the top of the address space
      applyStimulus(1'b1, 1'b0, 1'b0, cmdA(1'b0, 10'h3FE));
      checkOutput("load_only_ready", {31'd0, monitor_ready}, 32'd1);
      exp_q.push_back(mkAcc(1'b0, 12'hFF8, 32'h0));
      exp_q.push_back(mkAcc(1'b0, 12'hFFC, 32'h0));
      exp_q.push_back(mkAcc(1'b0, 12'h000, 32'h0));
      for (int k = 0; k < 3; k++) begin
         avm_readdata = 32'h1000 + k;
         applyStimulus(1'b0, 1'b1, 1'b0, '0);
         waitReady(20, n);
         checkOutput("stream_mondreg", MonDReg, 32'h1000 + k);
      end
      checkOutput("stream_wrap_addr", {20'd0, avm_address}, 32'h004);
      checkOutput("stream_error", {31'd0, monitor_error}, 32'd0);

      // Write stalled by five waitrequest cycles
      avm_waitrequest = 1'b1;
      exp_q.push_back(mkAcc(1'b1, 12'h004, 32'h12345678));
      applyStimulus(1'b0, 1'b0, 1'b1, cmdB(32'h12345678));
      held = 0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         if (avm_write) held++;
         checkOutput("wr_hold_data", avm_writedata, 32'h12345678);
         checkOutput("wr_hold_addr", {20'd0, avm_address}, 32'h004);
      end
      @(posedge clk);
      #1 avm_waitrequest = 1'b0;
      @(negedge clk);
      if (avm_write) held++;
      checkOutput("wr_strobe_cycles", held, 6);
      waitReady(20, n);
      checkOutput("wr_error", {31'd0, monitor_error}, 32'd0);
      checkOutput("wr_mondreg", MonDReg, 32'h12345678);
      checkOutput("wr_next_addr", {20'd0, avm_address}, 32'h008);

      // Read stuck in waitrequest until the timeout aborts it
      avm_waitrequest = 1'b1;
      avm_readdata    = 32'hAAAA5555;
      applyStimulus(1'b0, 1'b1, 1'b0, '0);
      strobes = 0;
      for (int k = 0; k < 1000; k++) begin
         @(negedge clk);
         if (avm_read) strobes++;
         else break;
      end
      checkOutput("to_strobe_cycles", strobes, 255);
      waitReady(20, n);
      checkOutput("to_error", {31'd0, monitor_error}, 32'd1);
      checkOutput("to_mondreg", MonDReg, 32'h12345678);
      checkOutput("to_addr", {20'd0, avm_address}, 32'h008);
      avm_waitrequest = 1'b0;

      // Overrun during a read, then simultaneous a+b
      applyStimulus(1'b1, 1'b0, 1'b0, cmdA(1'b0, 10'h020));
      checkOutput("clear_error", {31'd0, monitor_error}, 32'd0);
      avm_waitrequest = 1'b1;
      avm_readdata    = 32'h0BADF00D;
      exp_q.push_back(mkAcc(1'b0, 12'h080, 32'h0));
      applyStimulus(1'b0, 1'b1, 1'b0, '0);
      applyStimulus(1'b0, 1'b0, 1'b1, cmdB(32'hFFFFFFFF));
      checkOutput("overrun_error", {31'd0, monitor_error}, 32'd1);
      checkOutput("overrun_read_held", {31'd0, avm_read}, 32'd1);
      avm_waitrequest = 1'b0;
      waitReady(20, n);
      checkOutput("overrun_mondreg", MonDReg, 32'h0BADF00D);
      checkOutput("overrun_addr", {20'd0, avm_address}, 32'h084);

      avm_readdata = 32'h13579BDF;
      exp_q.push_back(mkAcc(1'b0, 12'h400, 32'h0));
      applyStimulus(1'b1, 1'b0, 1'b1, cmdA(1'b1, 10'h100));
      checkOutput("prio_error", {31'd0, monitor_error}, 32'd1);
      waitReady(20, n);
      checkOutput("prio_mondreg", MonDReg, 32'h13579BDF);
      checkOutput("prio_addr", {20'd0, avm_address}, 32'h404);
      applyStimulus(1'b1, 1'b0, 1'b0, cmdA(1'b0, 10'h005));
      checkOutput("reclear_error", {31'd0, monitor_error}, 32'd0);
      checkOutput("reload_addr", {20'd0, avm_address}, 32'h014);

      // Reset asserted in the middle of a stalled write
      avm_waitrequest = 1'b1;
      applyStimulus(1'b0, 1'b0, 1'b1, cmdB(32'hCAFEF00D));
      @(negedge clk);
      checkOutput("midwr_write", {31'd0, avm_write}, 32'd1);
      #2 reset_n = 1'b0;
      #1;
      checkOutput("async_rst_write", {31'd0, avm_write}, 32'd0);
      checkOutput("async_rst_ready", {31'd0, monitor_ready}, 32'd1);
      checkOutput("async_rst_mondreg", MonDReg, 32'd0);
      checkOutput("async_rst_addr", {20'd0, avm_address}, 32'd0);
      checkOutput("async_rst_error", {31'd0, monitor_error}, 32'd0);
      @(posedge clk);
      #1;
      reset_n         = 1'b1;
      avm_waitrequest = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("post_rst_write", {31'd0, avm_write}, 32'd0);
      checkOutput("post_rst_addr", {20'd0, avm_address}, 32'd0);
      checkOutput("scoreboard_empty", exp_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
